// File: rtl/toggle_counter_n_if.sv
// Control/status bundle for toggle_counter_n.
// The testbench or parent logic drives the master side.
interface toggle_counter_n_if #(
  parameter int WIDTH = 4
);
  logic             T;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             ovf;

  modport master (
    output T, up_dn, load, d,
    input  Q, tc, ovf
  );

  modport slave (
    input  T, up_dn, load, d,
    output Q, tc, ovf
  );
endinterface

// File: rtl/toggle_counter_n.sv
// N-bit counter built from per-bit toggle enables.
// Supports modulus, up/down, load with clamp, and wrap or saturate.
module toggle_counter_n #(
  parameter int     WIDTH    = 4,
  parameter longint MODULO   = 16,
  parameter bit     SATURATE = 1'b0
) (
  input  logic              Clk,
  input  logic              rst,
  toggle_counter_n_if.slave s
);

  localparam bit FULL =
    (64'(MODULO) == (64'd1 << WIDTH));
  localparam logic [WIDTH-1:0] MAXV =
    WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;

  logic [WIDTH-1:0] w_tnat;
  logic [WIDTH-1:0] w_tog;
  logic [WIDTH-1:0] w_tgt;
  logic [WIDTH-1:0] w_ld;
  logic             w_c;
  logic             w_max;
  logic             w_min;
  logic             w_bound;

  assign w_max   = (r_q == MAXV);
  assign w_min   = (r_q == '0);
  assign w_bound = s.up_dn ? w_max : w_min;
  assign w_tgt   = s.up_dn ? '0 : MAXV;

  // Ripple of "all lower bits 1 (up) / 0 (down)".
  always_comb begin
    w_tnat = '0;
    w_c    = s.T;
    for (int i = 0; i < WIDTH; i++) begin
      w_tnat[i] = w_c;
      w_c = w_c & (s.up_dn ? r_q[i] : ~r_q[i]);
    end
  end

  // At the range end, override the toggles unless
  // the binary rollover already lands on the target.
  always_comb begin
    w_tog = w_tnat;
    if (s.T && w_bound) begin
      if (SATURATE)
        w_tog = '0;
      else if (!FULL)
        w_tog = r_q ^ w_tgt;
    end
  end

  always_comb begin
    w_ld = s.d;
    if ({{(64-WIDTH){1'b0}}, s.d} >= 64'(MODULO))
      w_ld = MAXV;
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else if (s.load) begin
      r_q   <= w_ld;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= r_q ^ w_tog;
      r_ovf <= s.T & w_bound;
    end
  end

  assign s.Q   = r_q;
  assign s.ovf = r_ovf;
  assign s.tc  = w_bound;

endmodule

// File: tb/tb_toggle_counter_n.sv
// Directed bench for toggle_counter_n: wrap, saturate
// and full-range binary variants side by side.
module tb_toggle_counter_n;

  logic Clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  toggle_counter_n_if #(.WIDTH(4)) a_if ();
  toggle_counter_n_if #(.WIDTH(4)) s_if ();
  toggle_counter_n_if #(.WIDTH(3)) b_if ();

  toggle_counter_n #(
    .WIDTH(4), .MODULO(10), .SATURATE(1'b0)
  ) u_wrap (
    .Clk(Clk), .rst(rst), .s(a_if)
  );

  toggle_counter_n #(
    .WIDTH(4), .MODULO(10), .SATURATE(1'b1)
  ) u_sat (
    .Clk(Clk), .rst(rst), .s(s_if)
  );

  toggle_counter_n #(
    .WIDTH(3), .MODULO(8), .SATURATE(1'b0)
  ) u_bin (
    .Clk(Clk), .rst(rst), .s(b_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    a_if.T = 1'b1; a_if.up_dn = 1'b1;
    a_if.load = 1'b0; a_if.d = 4'd0;
    s_if.T = 1'b0; s_if.up_dn = 1'b1;
    s_if.load = 1'b0; s_if.d = 4'd0;
    b_if.T = 1'b0; b_if.up_dn = 1'b1;
    b_if.load = 1'b0; b_if.d = 3'd0;

    // 1. reset, release at 22, count up with wrap
    #3;
    chk("rst_q", 32'(a_if.Q), 0);
    chk("rst_ovf", 32'(a_if.ovf), 0);
    #19;
    chk("rst_hold_q", 32'(a_if.Q), 0);
    rst = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("up_q", 32'(a_if.Q), 32'(k));
      chk("up_ovf", 32'(a_if.ovf), 0);
      chk("up_tc", 32'(a_if.tc), (k == 9) ? 1 : 0);
    end
    step();
    chk("wrap_q", 32'(a_if.Q), 0);
    chk("wrap_ovf", 32'(a_if.ovf), 1);
    step();
    chk("post_wrap_q", 32'(a_if.Q), 1);
    chk("post_wrap_ovf", 32'(a_if.ovf), 0);

    // 2. async reset mid-cycle at Q=5
    repeat (4) step();
    chk("pre_rst_q", 32'(a_if.Q), 5);
    #3;
    rst = 1'b0;
    #1;
    chk("async_q", 32'(a_if.Q), 0);
    chk("async_ovf", 32'(a_if.ovf), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("release_nostep", 32'(a_if.Q), 0);
    step();
    chk("restart_q", 32'(a_if.Q), 1);

    // 3. down count from 0
    a_if.T = 1'b0; a_if.load = 1'b1; a_if.d = 4'd0;
    step();
    a_if.load = 1'b0; a_if.up_dn = 1'b0;
    #1;
    chk("dn_tc0", 32'(a_if.tc), 1);
    a_if.T = 1'b1;
    step();
    chk("dn_wrap_q", 32'(a_if.Q), 9);
    chk("dn_wrap_ovf", 32'(a_if.ovf), 1);
    chk("dn_tc9", 32'(a_if.tc), 0);
    step();
    chk("dn_q8", 32'(a_if.Q), 8);
    chk("dn_ovf8", 32'(a_if.ovf), 0);
    step();
    chk("dn_q7", 32'(a_if.Q), 7);

    // 4. load priority and clamp
    a_if.up_dn = 1'b1; a_if.load = 1'b1; a_if.d = 4'd7;
    step();
    chk("load7", 32'(a_if.Q), 7);
    chk("load7_ovf", 32'(a_if.ovf), 0);
    a_if.d = 4'd12;
    step();
    chk("load_clamp", 32'(a_if.Q), 9);
    chk("load_clamp_tc", 32'(a_if.tc), 1);
    a_if.load = 1'b0; a_if.T = 1'b0;
    step();
    chk("hold_q", 32'(a_if.Q), 9);
    chk("hold_ovf", 32'(a_if.ovf), 0);

    // 5. saturate at the top, then step down
    s_if.load = 1'b1; s_if.d = 4'd9;
    step();
    chk("sat_load", 32'(s_if.Q), 9);
    s_if.load = 1'b0; s_if.T = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("sat_q", 32'(s_if.Q), 9);
      chk("sat_ovf", 32'(s_if.ovf), 1);
    end
    s_if.up_dn = 1'b0;
    step();
    chk("sat_dn_q", 32'(s_if.Q), 8);
    chk("sat_dn_ovf", 32'(s_if.ovf), 0);
    s_if.T = 1'b0;

    // 6. 3-bit full range with a T gap
    b_if.T = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("bin_q", 32'(b_if.Q), 32'(k));
    end
    b_if.T = 1'b0;
    repeat (3) begin
      step();
      chk("bin_hold", 32'(b_if.Q), 3);
      chk("bin_hold_ovf", 32'(b_if.ovf), 0);
    end
    b_if.T = 1'b1;
    for (int k = 4; k <= 7; k++) begin
      step();
      chk("bin_q2", 32'(b_if.Q), 32'(k));
      chk("bin_tc", 32'(b_if.tc), (k == 7) ? 1 : 0);
    end
    step();
    chk("bin_wrap_q", 32'(b_if.Q), 0);
    chk("bin_wrap_ovf", 32'(b_if.ovf), 1);
    chk("bin_wrap_tc", 32'(b_if.tc), 0);
    b_if.up_dn = 1'b0;
    step();
    chk("bin_dn_q", 32'(b_if.Q), 7);
    chk("bin_dn_ovf", 32'(b_if.ovf), 1);
    step();
    chk("bin_dn_q6", 32'(b_if.Q), 6);
    b_if.T = 1'b0;

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
